// File: rtl/systolic_pkg.sv
// Shared types and widths for the systolic-array sequencer.
package systolic_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 64;
  // Phase counter width; wide enough for N_IN/N_OUT up to 1024 and long flush windows.
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFeed,
    StFlush,
    StDrain,
    StRead
  } seq_state_e;

endpackage

// File: rtl/seq_res_buf.sv
// Single-entry result register: loads a word read from the output SRAM and holds
// it with valid high until the host takes it.
module seq_res_buf
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_hs
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Load wins over the handshake; the sequencer never loads while a word is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_hs    = r_valid & i_ready;

endmodule

// File: rtl/systolic_seq.sv
// Job sequencer for the 4x4 systolic array: load operands into the input SRAM,
// stream them into the array, flush, drain results into the output SRAM and
// return them to the host. Optional cycle counter under SEQ_PERF_CNT_EN.
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int unsigned N_IN      = 10,
  parameter int unsigned N_OUT     = 4,
  parameter int unsigned FLUSH_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic [DATA_W-1:0] ram_din,
  output logic              wr_in,
  output logic              input_en_ramin,
  output logic [ADDR_W-1:0] adder_in,
  output logic              input_en_sys,
  output logic              output_en_sys,
  output logic              input_en_ramout,
  output logic              wr_out,
  output logic [ADDR_W-1:0] adder_out,
  input  logic [DATA_W-1:0] rd_sram_out,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready,
  output logic              busy,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0]       cyc_cnt,
`endif
  output logic              done
);

  seq_state_e        r_state, w_state_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_load_ready, w_load_ready_d;
  logic              r_ramin_cs, w_ramin_cs_d;
  logic [ADDR_W-1:0] r_adder_in, w_adder_in_d;
  logic              r_input_en_sys, w_input_en_sys_d;
  logic              r_output_en_sys, w_output_en_sys_d;
  logic              r_ramout_cs, w_ramout_cs_d;
  logic              r_wr_out, w_wr_out_d;
  logic [ADDR_W-1:0] r_adder_out, w_adder_out_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;

  logic              w_load_hs;
  logic              w_rd_capture;
  logic              w_res_hs;

  // Operand writes happen in the handshake cycle itself, so they bypass the registers.
  assign w_load_hs    = r_load_ready & load_valid;
  // A read issued this cycle has its data at the SRAM output by the next edge.
  assign w_rd_capture = (r_state == StRead) & r_ramout_cs & ~r_wr_out;

  // State and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= StIdle;
      r_cnt           <= '0;
      r_load_ready    <= 1'b0;
      r_ramin_cs      <= 1'b0;
      r_adder_in      <= '0;
      r_input_en_sys  <= 1'b0;
      r_output_en_sys <= 1'b0;
      r_ramout_cs     <= 1'b0;
      r_wr_out        <= 1'b0;
      r_adder_out     <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_state_d;
      r_cnt           <= w_cnt_d;
      r_load_ready    <= w_load_ready_d;
      r_ramin_cs      <= w_ramin_cs_d;
      r_adder_in      <= w_adder_in_d;
      r_input_en_sys  <= w_input_en_sys_d;
      r_output_en_sys <= w_output_en_sys_d;
      r_ramout_cs     <= w_ramout_cs_d;
      r_wr_out        <= w_wr_out_d;
      r_adder_out     <= w_adder_out_d;
      r_busy          <= w_busy_d;
      r_done          <= w_done_d;
    end
  end

  // Next state and next-cycle output values; r_cnt is the position within the phase.
  always_comb begin
    w_state_d         = r_state;
    w_cnt_d           = r_cnt;
    w_load_ready_d    = 1'b0;
    w_ramin_cs_d      = 1'b0;
    w_adder_in_d      = '0;
    w_input_en_sys_d  = 1'b0;
    w_output_en_sys_d = 1'b0;
    w_ramout_cs_d     = 1'b0;
    w_wr_out_d        = 1'b0;
    w_adder_out_d     = '0;
    w_done_d          = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d      = StLoad;
          w_cnt_d        = '0;
          w_load_ready_d = 1'b1;
        end
      end
      StLoad: begin
        w_load_ready_d = 1'b1;
        w_adder_in_d   = r_adder_in;
        if (w_load_hs) begin
          if (r_cnt == CNT_W'(N_IN - 1)) begin
            w_state_d      = StFeed;
            w_cnt_d        = '0;
            w_load_ready_d = 1'b0;
            w_ramin_cs_d   = 1'b1;
            w_adder_in_d   = '0;
          end else begin
            w_cnt_d      = r_cnt + 1'b1;
            w_adder_in_d = r_adder_in + 1'b1;
          end
        end
      end
      StFeed: begin
        // The array consumes one cycle behind each read.
        w_input_en_sys_d = r_ramin_cs;
        if (r_cnt == CNT_W'(N_IN)) begin
          w_cnt_d = '0;
          if (FLUSH_CYC == 0) begin
            w_state_d         = StDrain;
            w_output_en_sys_d = 1'b1;
          end else begin
            w_state_d = StFlush;
          end
        end else begin
          w_cnt_d = r_cnt + 1'b1;
          if (r_cnt < CNT_W'(N_IN - 1)) begin
            w_ramin_cs_d = 1'b1;
            w_adder_in_d = ADDR_W'(r_cnt + 1'b1);
          end
        end
      end
      StFlush: begin
        if (r_cnt == CNT_W'(FLUSH_CYC - 1)) begin
          w_state_d         = StDrain;
          w_cnt_d           = '0;
          w_output_en_sys_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StDrain: begin
        // Each array output cycle is followed by a write of that word.
        w_ramout_cs_d = r_output_en_sys;
        w_wr_out_d    = r_output_en_sys;
        w_adder_out_d = r_output_en_sys ? ADDR_W'(r_cnt) : '0;
        if (r_cnt == CNT_W'(N_OUT)) begin
          w_state_d     = StRead;
          w_cnt_d       = '0;
          w_ramout_cs_d = 1'b1;
          w_wr_out_d    = 1'b0;
          w_adder_out_d = '0;
        end else begin
          w_cnt_d           = r_cnt + 1'b1;
          w_output_en_sys_d = (r_cnt < CNT_W'(N_OUT - 1));
        end
      end
      StRead: begin
        if (w_res_hs) begin
          if (r_cnt == CNT_W'(N_OUT - 1)) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
            w_done_d  = 1'b1;
          end else begin
            w_cnt_d       = r_cnt + 1'b1;
            w_ramout_cs_d = 1'b1;
            w_adder_out_d = ADDR_W'(r_cnt + 1'b1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    w_busy_d = (w_state_d != StIdle);
  end

  seq_res_buf u_res_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_rd_capture),
    .i_data  (rd_sram_out),
    .i_ready (res_ready),
    .o_valid (res_valid),
    .o_data  (res_data),
    .o_hs    (w_res_hs)
  );

  assign load_ready      = r_load_ready;
  assign wr_in           = w_load_hs;
  assign ram_din         = w_load_hs ? load_data : '0;
  assign input_en_ramin  = r_ramin_cs | w_load_hs;
  assign adder_in        = r_adder_in;
  assign input_en_sys    = r_input_en_sys;
  assign output_en_sys   = r_output_en_sys;
  assign input_en_ramout = r_ramout_cs;
  assign wr_out          = r_wr_out;
  assign adder_out       = r_adder_out;
  assign busy            = r_busy;
  assign done            = r_done;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_cyc_cnt;

  // The start cycle counts as the first job cycle, so the total equals start-to-done latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc_cnt <= '0;
    end else if ((r_state == StIdle) && start) begin
      r_cyc_cnt <= 32'd1;
    end else if (r_busy && (r_cyc_cnt != '1)) begin
      r_cyc_cnt <= r_cyc_cnt + 1'b1;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Directed bench for systolic_seq with behavioural input/output SRAM models.
// Covers SEQ_PERF_CNT_EN when that macro is defined for the build.
module tb_systolic_seq;

  localparam logic [63:0] RES_BASE = 64'hC0DE_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        load_valid;
  logic [63:0] load_data;
  logic        load_ready;
  logic [63:0] ram_din;
  logic        wr_in;
  logic        input_en_ramin;
  logic [9:0]  adder_in;
  logic        input_en_sys;
  logic        output_en_sys;
  logic        input_en_ramout;
  logic        wr_out;
  logic [9:0]  adder_out;
  logic [63:0] rd_sram_out;
  logic        res_valid;
  logic [63:0] res_data;
  logic        res_ready;
  logic        busy;
  logic        done;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_cnt;
`endif

  systolic_seq #(
    .N_IN      (10),
    .N_OUT     (4),
    .FLUSH_CYC (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .load_valid      (load_valid),
    .load_data       (load_data),
    .load_ready      (load_ready),
    .ram_din         (ram_din),
    .wr_in           (wr_in),
    .input_en_ramin  (input_en_ramin),
    .adder_in        (adder_in),
    .input_en_sys    (input_en_sys),
    .output_en_sys   (output_en_sys),
    .input_en_ramout (input_en_ramout),
    .wr_out          (wr_out),
    .adder_out       (adder_out),
    .rd_sram_out     (rd_sram_out),
    .res_valid       (res_valid),
    .res_data        (res_data),
    .res_ready       (res_ready),
    .busy            (busy),
`ifdef SEQ_PERF_CNT_EN
    .cyc_cnt         (cyc_cnt),
`endif
    .done            (done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic        log_clr;
  logic        lv_en;
  logic        lv_toggle;
  logic [63:0] data_base;

  // Per-job log, filled by the monitor.
  int ld_idx, ld_bad, in_wr_cnt, in_wr_bad, sys_cnt, sys_bad;
  int out_wr_cnt, out_wr_bad, rd_cnt, last_rd_addr, res_cnt, res_bad, done_cnt;
  int t_start, t_last_ld, t_first_rd, t_first_sys, t_last_sys, t_first_oe, t_done;
  logic busy_at_done;

  logic [63:0] mem_in  [1024];
  logic [63:0] mem_out [1024];
  logic [63:0] in_dout;
  logic [63:0] accout;

  assign load_valid  = lv_en & (lv_toggle ? cyc[0] : 1'b1);
  assign load_data   = data_base + 64'(ld_idx);
  assign accout      = RES_BASE + 64'(out_wr_cnt);
  assign rd_sram_out = (input_en_ramout && !wr_out) ? mem_out[adder_out] : 64'hDEAD_BEEF_DEAD_BEEF;

  // SRAM models.
  always @(posedge clk) begin
    if (input_en_ramin && wr_in) mem_in[adder_in] <= ram_din;
    if (input_en_ramin && !wr_in) in_dout <= mem_in[adder_in];
    if (input_en_ramout && wr_out) mem_out[adder_out] <= accout;
  end

  // Protocol monitor and scoreboard.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (log_clr) begin
      ld_idx <= 0; ld_bad <= 0; in_wr_cnt <= 0; in_wr_bad <= 0; sys_cnt <= 0; sys_bad <= 0;
      out_wr_cnt <= 0; out_wr_bad <= 0; rd_cnt <= 0; last_rd_addr <= -1; res_cnt <= 0;
      res_bad <= 0; done_cnt <= 0; busy_at_done <= 1'b1;
      t_start <= -1; t_last_ld <= -1; t_first_rd <= -1; t_first_sys <= -1;
      t_last_sys <= -1; t_first_oe <= -1; t_done <= -1;
    end else begin
      if (start && !busy) t_start <= cyc;
      if (load_valid && load_ready) begin
        ld_idx    <= ld_idx + 1;
        t_last_ld <= cyc;
      end
      if (load_ready && !load_valid && (int'(adder_in) != in_wr_cnt)) ld_bad <= ld_bad + 1;
      if (input_en_ramin && wr_in) begin
        in_wr_cnt <= in_wr_cnt + 1;
        if ((int'(adder_in) != in_wr_cnt) || (ram_din !== data_base + 64'(in_wr_cnt)))
          in_wr_bad <= in_wr_bad + 1;
      end
      if (input_en_ramin && !wr_in && (t_first_rd < 0)) t_first_rd <= cyc;
      if (input_en_sys) begin
        sys_cnt <= sys_cnt + 1;
        if (in_dout !== data_base + 64'(sys_cnt)) sys_bad <= sys_bad + 1;
        if (t_first_sys < 0) t_first_sys <= cyc;
        t_last_sys <= cyc;
      end
      if (output_en_sys && (t_first_oe < 0)) t_first_oe <= cyc;
      if (input_en_ramout && wr_out) begin
        out_wr_cnt <= out_wr_cnt + 1;
        if (int'(adder_out) != out_wr_cnt) out_wr_bad <= out_wr_bad + 1;
      end
      if (input_en_ramout && !wr_out) begin
        rd_cnt       <= rd_cnt + 1;
        last_rd_addr <= int'(adder_out);
      end
      if (res_valid && res_ready) begin
        res_cnt <= res_cnt + 1;
        if (res_data !== RES_BASE + 64'(res_cnt)) res_bad <= res_bad + 1;
      end
      if (done) begin
        done_cnt     <= done_cnt + 1;
        t_done       <= cyc;
        busy_at_done <= busy;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ctl_vec();
    return {54'b0, busy, done, load_ready, wr_in, input_en_ramin, input_en_sys,
            output_en_sys, input_en_ramout, wr_out, res_valid};
  endfunction

  task automatic new_job(input logic [63:0] base);
    @(negedge clk);
    data_base = base;
    log_clr   = 1'b1;
    @(negedge clk);
    log_clr   = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && done_cnt == 0; i++) @(negedge clk);
    chk(tag, 64'(done_cnt != 0), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  int          bad;
  int          stable_bad;
  logic [63:0] hold;

  initial begin
    rst = 1'b1; start = 1'b0; res_ready = 1'b1; lv_en = 1'b1; lv_toggle = 1'b0;
    log_clr = 1'b0; data_base = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", ctl_vec(), 64'd0);
    chk("rst_addr", {44'b0, adder_in, adder_out}, 64'd0);
    chk("rst_ram_din", ram_din, 64'd0);
    chk("rst_res_data", res_data, 64'd0);
`ifdef SEQ_PERF_CNT_EN
    chk("rst_cyc_cnt", 64'(cyc_cnt), 64'd0);
`endif
    rst = 1'b0;

    // Job A: all sources and sinks ready.
    new_job(64'd0);
    pulse_start();
    chk("A_load_ready_t1", 64'(load_ready), 64'd1);
    wait_done("A_done_timeout");
    chk("A_in_writes", 64'(in_wr_cnt), 64'd10);
    chk("A_in_wr_bad", 64'(in_wr_bad), 64'd0);
    bad = 0;
    for (int k = 0; k < 10; k++) if (mem_in[k] !== 64'(k)) bad++;
    chk("A_mem_in", 64'(bad), 64'd0);
    chk("A_last_load", 64'(t_last_ld - t_start), 64'd10);
    chk("A_first_rd", 64'(t_first_rd - t_last_ld), 64'd1);
    chk("A_first_sys", 64'(t_first_sys - t_last_ld), 64'd2);
    chk("A_sys_cycles", 64'(sys_cnt), 64'd10);
    chk("A_sys_span", 64'(t_last_sys - t_first_sys), 64'd9);
    chk("A_sys_data", 64'(sys_bad), 64'd0);
    chk("A_first_oe", 64'(t_first_oe - t_last_sys), 64'd9);
    chk("A_out_writes", 64'(out_wr_cnt), 64'd4);
    chk("A_out_wr_bad", 64'(out_wr_bad), 64'd0);
    chk("A_results", 64'(res_cnt), 64'd4);
    chk("A_res_bad", 64'(res_bad), 64'd0);
    chk("A_done_once", 64'(done_cnt), 64'd1);
    chk("A_job_len", 64'(t_done - t_start), 64'd43);
    chk("A_busy_at_done", 64'(busy_at_done), 64'd0);
`ifdef SEQ_PERF_CNT_EN
    chk("A_cyc_cnt", 64'(cyc_cnt), 64'd43);
    repeat (5) @(negedge clk);
    chk("A_cyc_cnt_hold", 64'(cyc_cnt), 64'd43);
`endif

    // Job B: load_valid toggling.
    new_job(64'd100);
    lv_toggle = 1'b1;
    pulse_start();
    wait_done("B_done_timeout");
    lv_toggle = 1'b0;
    chk("B_in_writes", 64'(in_wr_cnt), 64'd10);
    chk("B_in_wr_bad", 64'(in_wr_bad), 64'd0);
    chk("B_addr_idle", 64'(ld_bad), 64'd0);
    chk("B_sys_data", 64'(sys_bad), 64'd0);
    chk("B_results", 64'(res_cnt), 64'd4);
    chk("B_res_bad", 64'(res_bad), 64'd0);

    // Job C: start pulsed during FEED is ignored.
    new_job(64'd200);
    pulse_start();
    for (int i = 0; i < 60 && !input_en_sys; i++) @(negedge clk);
    chk("C_feed_seen", 64'(input_en_sys), 64'd1);
    pulse_start();
    wait_done("C_done_timeout");
    chk("C_job_len", 64'(t_done - t_start), 64'd43);
    chk("C_done_once", 64'(done_cnt), 64'd1);
    chk("C_in_writes", 64'(in_wr_cnt), 64'd10);
    chk("C_idle_after", {62'b0, busy, load_ready}, 64'd0);

    // Job D: host stalls on result 2.
    new_job(64'd300);
    pulse_start();
    for (int i = 0; i < 200 && res_cnt < 2; i++) @(negedge clk);
    res_ready = 1'b0;
    for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
    chk("D_valid_seen", 64'(res_valid), 64'd1);
    hold = res_data;
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ((res_data !== hold) || !res_valid) stable_bad++;
    end
    chk("D_stable", 64'(stable_bad), 64'd0);
    chk("D_hold_val", hold, RES_BASE + 64'd2);
    chk("D_reads_held", 64'(rd_cnt), 64'd3);
    chk("D_last_rd_addr", 64'(last_rd_addr), 64'd2);
    res_ready = 1'b1;
    wait_done("D_done_timeout");
    chk("D_results", 64'(res_cnt), 64'd4);
    chk("D_res_bad", 64'(res_bad), 64'd0);
    chk("D_reads_total", 64'(rd_cnt), 64'd4);

    // Job E: reset mid-DRAIN, then a clean job F.
    new_job(64'd400);
    pulse_start();
    for (int i = 0; i < 100 && !output_en_sys; i++) @(negedge clk);
    chk("E_drain_seen", 64'(output_en_sys), 64'd1);
    rst = 1'b1;
    #1;
    chk("E_rst_ctl", ctl_vec(), 64'd0);
    chk("E_rst_addr", {44'b0, adder_in, adder_out}, 64'd0);
    chk("E_rst_data", res_data | ram_din, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    new_job(64'd500);
    pulse_start();
    wait_done("F_done_timeout");
    chk("F_in_writes", 64'(in_wr_cnt), 64'd10);
    chk("F_sys_data", 64'(sys_bad), 64'd0);
    chk("F_sys_cycles", 64'(sys_cnt), 64'd10);
    chk("F_out_writes", 64'(out_wr_cnt), 64'd4);
    chk("F_results", 64'(res_cnt), 64'd4);
    chk("F_res_bad", 64'(res_bad), 64'd0);
    chk("F_job_len", 64'(t_done - t_start), 64'd43);
    chk("F_done_once", 64'(done_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
